ru_sb: RTL and testbench

RU_SB -- requirements
Module: ru_sb

---
 rtl/ru_sb.sv | 112 +++++++++++
 tb/tb_ru_sb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ru_sb.sv
// ru_sb: register file with a per-register pending (scoreboard) bit.
// Clear sweep zeroes the file after reset, then RUN serves reads/writes.
//
// Ports:
//   CLK, RST_N       clock, synchronous active-low reset
//   rs1, rs2         read addresses -> RUrs1, RUrs2 (combinational)
//   rd, DataWr, RUWr write port
//   iss_vld, iss_rd  issue strobe, marks iss_rd pending
//   busy1, busy2     pending bit of rs1 / rs2
//   rdy              sweep finished, unit in RUN
// Optional: define RU_SB_BYPASS_EN to forward same-cycle writes to reads.
module ru_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] RUrs1,
  output logic [XLEN-1:0] RUrs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] DataWr,
  input  logic            RUWr,
  input  logic            iss_vld,
  input  logic [AW-1:0]   iss_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            rdy
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  localparam logic [AW-1:0] ZERO = '0;

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= CLEAR;
      ptr     <= '0;
      rdy     <= 1'b0;
      pending <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          regs[ptr] <= '0;
          ptr       <= ptr + AW'(1);
          if (ptr == LAST) begin
            state <= RUN;
            rdy   <= 1'b1;
          end
        end
        RUN: begin
          if (RUWr && rd != ZERO) begin
            regs[rd]    <= DataWr;
            pending[rd] <= 1'b0;
          end
          // issue is applied last so it wins over a same-edge write
          if (iss_vld && iss_rd != ZERO)
            pending[iss_rd] <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

`ifdef RU_SB_BYPASS_EN
  logic byp_wr;
  logic byp_iss;
  assign byp_wr  = RUWr && (rd != ZERO);
  assign byp_iss = iss_vld && (iss_rd == rd);
`endif

  always_comb begin
    RUrs1 = '0;
    RUrs2 = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (rdy) begin
      if (rs1 != ZERO) begin
        RUrs1 = regs[rs1];
        busy1 = pending[rs1];
      end
      if (rs2 != ZERO) begin
        RUrs2 = regs[rs2];
        busy2 = pending[rs2];
      end
`ifdef RU_SB_BYPASS_EN
      if (byp_wr && rd == rs1) begin
        RUrs1 = DataWr;
        if (!byp_iss)
          busy1 = 1'b0;
      end
      if (byp_wr && rd == rs2) begin
        RUrs2 = DataWr;
        if (!byp_iss)
          busy2 = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ru_sb.sv
// tb_ru_sb: directed bench for ru_sb, default and XLEN=16/NREG=8 builds.
// Expectations go through a queue and are checked by immediate asserts.
module tb_ru_sb;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [4:0]  rs1, rs2, rd, iss_rd;
  logic [31:0] RUrs1, RUrs2, DataWr;
  logic        RUWr, iss_vld, busy1, busy2, rdy;

  logic [2:0]  s_rs1, s_rs2, s_rd, s_iss_rd;
  logic [15:0] s_RUrs1, s_RUrs2, s_DataWr;
  logic        s_RUWr, s_iss_vld, s_busy1, s_busy2, s_rdy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] q_exp[$];
  string       q_tag[$];
  int c32, c8;

  always #5 CLK = ~CLK;

  ru_sb u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .rs1(rs1), .rs2(rs2), .RUrs1(RUrs1), .RUrs2(RUrs2),
    .rd(rd), .DataWr(DataWr), .RUWr(RUWr),
    .iss_vld(iss_vld), .iss_rd(iss_rd),
    .busy1(busy1), .busy2(busy2), .rdy(rdy)
  );

  ru_sb #(.XLEN(16), .NREG(8)) u_small (
    .CLK(CLK), .RST_N(RST_N),
    .rs1(s_rs1), .rs2(s_rs2), .RUrs1(s_RUrs1), .RUrs2(s_RUrs2),
    .rd(s_rd), .DataWr(s_DataWr), .RUWr(s_RUWr),
    .iss_vld(s_iss_vld), .iss_rd(s_iss_rd),
    .busy1(s_busy1), .busy2(s_busy2), .rdy(s_rdy)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string t, input logic [63:0] e);
    q_tag.push_back(t);
    q_exp.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    string t;
    logic [63:0] e;
    n_cmp++;
    if (q_exp.size() == 0) begin
      n_bad++;
      $error("FAIL underflow: got %0h required nothing", obs);
      return;
    end
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: got %0h required %0h", t, obs, e);
    end
  endtask

  task automatic idle();
    RUWr = 0; rd = 0; DataWr = 0; iss_vld = 0; iss_rd = 0;
    s_RUWr = 0; s_rd = 0; s_DataWr = 0; s_iss_vld = 0; s_iss_rd = 0;
  endtask

  // edges after the current point until each rdy rises; 0 = timeout
  task automatic wait_rdy(output int n32, output int n8);
    n32 = 0;
    n8 = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (rdy && n32 == 0) n32 = i;
      if (s_rdy && n8 == 0) n8 = i;
      if (n32 != 0 && n8 != 0) break;
    end
  endtask

  initial begin
    RST_N = 0;
    idle();
    rs1 = 5; rs2 = 0; s_rs1 = 0; s_rs2 = 0;
    RUWr = 1; rd = 5; DataWr = 32'h1111_1111;
    iss_vld = 1; iss_rd = 5;
    tick();
    tick();
    push("rst_rdy", 0);    chk(rdy);
    push("rst_rdata", 0);  chk(RUrs1);
    push("rst_busy", 0);   chk(busy1);
    push("rst_srdy", 0);   chk(s_rdy);

    // first CLEAR edge with write/issue present: both ignored
    RST_N = 1;
    tick();
    idle();
    push("clr_rdata", 0);  chk(RUrs1);
    push("clr_busy", 0);   chk(busy1);
    wait_rdy(c32, c8);
    push("sweep32", 32);   chk(c32 == 0 ? 0 : c32 + 1);
    push("sweep8", 8);     chk(c8 == 0 ? 0 : c8 + 1);

    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      push($sformatf("zero_r1_%0d", i), 0); chk(RUrs1);
      push($sformatf("zero_r2_%0d", i), 0); chk(RUrs2);
      push($sformatf("idle_b1_%0d", i), 0); chk(busy1);
      push($sformatf("idle_b2_%0d", i), 0); chk(busy2);
    end

    // small build: top register holds full-width data
    s_rd = 7; s_DataWr = 16'hFFFF; s_RUWr = 1;
    push("small_r7", 64'hFFFF);
    tick();
    idle();
    s_rs1 = 7;
    #1;
    chk(s_RUrs1);

    // basic write, then write to x0
    rd = 5; DataWr = 32'hDEADBEEF; RUWr = 1;
    push("wr_r5", 32'hDEADBEEF);
    tick();
    idle();
    rs1 = 5;
    #1;
    chk(RUrs1);
    rd = 0; DataWr = 32'h1234; RUWr = 1;
    iss_vld = 1; iss_rd = 0;
    push("wr_r0", 0);
    push("busy_r0", 0);
    tick();
    idle();
    rs2 = 0;
    #1;
    chk(RUrs2);
    chk(busy2);

    // issue marks pending, both ports agree
    iss_vld = 1; iss_rd = 7;
    push("iss_b1", 1);
    push("iss_b2", 1);
    tick();
    idle();
    rs1 = 7; rs2 = 7;
    #1;
    chk(busy1);
    chk(busy2);
    push("same_port", 1); chk(RUrs1 === RUrs2);

    // write retires pending
    rd = 7; DataWr = 32'h77; RUWr = 1;
    push("ret_b1", 0);
    push("ret_d1", 32'h77);
    tick();
    idle();
    #1;
    chk(busy1);
    chk(RUrs1);

    // same-edge write and issue: data lands, pending stays
    rd = 7; DataWr = 32'h88; RUWr = 1;
    iss_vld = 1; iss_rd = 7;
    push("wi_b1", 1);
    push("wi_d1", 32'h88);
    tick();
    idle();
    #1;
    chk(busy1);
    chk(RUrs1);

    // forwarding on pending register 9
    iss_vld = 1; iss_rd = 9;
    tick();
    idle();
    rs1 = 9; rs2 = 9;
    rd = 9; DataWr = 32'hA5A5A5A5; RUWr = 1;
    #1;
`ifdef RU_SB_BYPASS_EN
    push("byp_d1", 32'hA5A5A5A5);
    push("byp_d2", 32'hA5A5A5A5);
    push("byp_b1", 0);
`else
    push("byp_d1", 0);
    push("byp_d2", 0);
    push("byp_b1", 1);
`endif
    chk(RUrs1);
    chk(RUrs2);
    chk(busy1);
    tick();
    idle();
    push("post_d1", 32'hA5A5A5A5); chk(RUrs1);
    push("post_b1", 0);            chk(busy1);

    // reset mid-sweep and in RUN
    rd = 3; DataWr = 32'h55; RUWr = 1;
    iss_vld = 1; iss_rd = 3;
    tick();
    idle();
    rs1 = 3; rs2 = 5;
    #1;
    push("pre_d3", 32'h55); chk(RUrs1);
    push("pre_b3", 1);      chk(busy1);
    RST_N = 0;
    tick();
    RST_N = 1;
    for (int i = 0; i < 16; i++) tick();
    push("mid_rdy", 0); chk(rdy);
    RST_N = 0;
    tick();
    RST_N = 1;
    wait_rdy(c32, c8);
    push("resweep32", 32); chk(c32);
    push("resweep8", 8);   chk(c8);
    push("rst_d3", 0); chk(RUrs1);
    push("rst_b3", 0); chk(busy1);
    push("rst_d5", 0); chk(RUrs2);

    rd = 6; DataWr = 32'h66; RUWr = 1;
    RST_N = 0;
    push("run_rst_rdy", 0);
    tick();
    chk(rdy);
    idle();
    RST_N = 1;
    wait_rdy(c32, c8);
    push("run_rst_sweep", 32); chk(c32);
    rs1 = 6;
    #1;
    push("run_rst_d6", 0); chk(RUrs1);

    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d entries required 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
